// File: rtl/avr_cpu.sv
// Compact AVR-subset core: single-cycle execute with a small FSM for
// LDS/STS (two-word) and LD X data-memory accesses.
module avr_cpu (
  input  logic        clock,
  input  logic        reset,
  input  logic        locked,
  output logic [15:0] pc,
  input  logic [15:0] ir,
  output logic [15:0] address,
  input  logic [7:0]  data,
  output logic [7:0]  wb,
  output logic        w
);
  typedef enum logic [1:0] {S_EXEC, S_ADDR, S_LOAD, S_LOADX} state_e;
  typedef enum logic [2:0] {A_NONE, A_ADD, A_SUB, A_LOGIC, A_INC, A_DEC} alu_e;

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d, addr_q, addr_d;
  logic [7:0]       wb_q, wb_d, sreg_q, sreg_d;
  logic             w_q, w_d, st_q, st_d;
  logic [4:0]       lreg_q, lreg_d;
  logic [31:0][7:0] rf_q, rf_d;

  alu_e       alu;
  logic [7:0] op_a, op_b, lres, res;
  logic [8:0] full;
  logic       cin, zkeep, wr;
  logic [4:0] dst;

  logic [4:0] rd, rr, rdi;
  logic [7:0] kimm;
  assign rd   = ir[8:4];
  assign rr   = {ir[9], ir[3:0]};
  assign rdi  = {1'b1, ir[7:4]};
  assign kimm = {ir[11:8], ir[3:0]};

  always_comb begin
    state_d = state_q; pc_d = pc_q; addr_d = addr_q; wb_d = wb_q; w_d = 1'b0;
    sreg_d = sreg_q; st_d = st_q; lreg_d = lreg_q; rf_d = rf_q;
    alu = A_NONE; op_a = rf_q[rd]; op_b = rf_q[rr]; cin = 1'b0; zkeep = 1'b0;
    wr = 1'b0; dst = rd; lres = 8'h00;
    case (state_q)
      S_EXEC: begin
        pc_d = pc_q + 16'd1;
        casez (ir)
          16'b1001_000?_????_0000: begin lreg_d = rd; st_d = 1'b0; state_d = S_ADDR; end
          16'b1001_001?_????_0000: begin lreg_d = rd; st_d = 1'b1; state_d = S_ADDR; end
          16'b1001_000?_????_1100: begin
            addr_d = {rf_q[27], rf_q[26]}; lreg_d = rd; state_d = S_LOADX;
          end
          16'b1001_001?_????_1100: begin
            addr_d = {rf_q[27], rf_q[26]}; wb_d = rf_q[rd]; w_d = 1'b1;
          end
          16'b1001_010?_????_0011: begin alu = A_INC; wr = 1'b1; end
          16'b1001_010?_????_1010: begin alu = A_DEC; wr = 1'b1; end
          16'b0000_01??_????_????: begin alu = A_SUB; cin = sreg_q[0]; zkeep = 1'b1; end
          16'b0000_10??_????_????: begin alu = A_SUB; cin = sreg_q[0]; zkeep = 1'b1; wr = 1'b1; end
          16'b0000_11??_????_????: begin alu = A_ADD; wr = 1'b1; end
          16'b0001_01??_????_????: alu = A_SUB;
          16'b0001_10??_????_????: begin alu = A_SUB; wr = 1'b1; end
          16'b0001_11??_????_????: begin alu = A_ADD; cin = sreg_q[0]; wr = 1'b1; end
          16'b0010_00??_????_????: begin alu = A_LOGIC; lres = op_a & op_b; wr = 1'b1; end
          16'b0010_01??_????_????: begin alu = A_LOGIC; lres = op_a ^ op_b; wr = 1'b1; end
          16'b0010_10??_????_????: begin alu = A_LOGIC; lres = op_a | op_b; wr = 1'b1; end
          16'b0010_11??_????_????: rf_d[rd] = rf_q[rr];
          16'b0011_????_????_????: begin alu = A_SUB; op_a = rf_q[rdi]; op_b = kimm; dst = rdi; end
          16'b0100_????_????_????: begin
            alu = A_SUB; op_a = rf_q[rdi]; op_b = kimm; dst = rdi;
            cin = sreg_q[0]; zkeep = 1'b1; wr = 1'b1;
          end
          16'b0101_????_????_????: begin
            alu = A_SUB; op_a = rf_q[rdi]; op_b = kimm; dst = rdi; wr = 1'b1;
          end
          16'b0110_????_????_????: begin
            alu = A_LOGIC; op_a = rf_q[rdi]; lres = op_a | kimm; dst = rdi; wr = 1'b1;
          end
          16'b0111_????_????_????: begin
            alu = A_LOGIC; op_a = rf_q[rdi]; lres = op_a & kimm; dst = rdi; wr = 1'b1;
          end
          16'b1110_????_????_????: rf_d[rdi] = kimm;
          16'b1100_????_????_????: pc_d = pc_q + 16'd1 + {{4{ir[11]}}, ir[11:0]};
          16'b1111_00??_????_????:
            if (sreg_q[ir[2:0]]) pc_d = pc_q + 16'd1 + {{9{ir[9]}}, ir[9:3]};
          16'b1111_01??_????_????:
            if (!sreg_q[ir[2:0]]) pc_d = pc_q + 16'd1 + {{9{ir[9]}}, ir[9:3]};
          default: ;
        endcase
      end
      // ir carries the absolute address word k here
      S_ADDR: begin
        addr_d = ir;
        if (st_q) begin
          wb_d = rf_q[lreg_q]; w_d = 1'b1; pc_d = pc_q + 16'd1; state_d = S_EXEC;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin rf_d[lreg_q] = data; pc_d = pc_q + 16'd1; state_d = S_EXEC; end
      S_LOADX: begin rf_d[lreg_q] = data; state_d = S_EXEC; end
    endcase

    if (alu == A_SUB) full = {1'b0, op_a} - {1'b0, op_b} - {8'h00, cin};
    else              full = {1'b0, op_a} + {1'b0, op_b} + {8'h00, cin};
    res = 8'h00;
    case (alu)
      A_ADD: begin
        res = full[7:0]; sreg_d[0] = full[8];
        sreg_d[5] = (op_a[3] & op_b[3]) | (op_b[3] & ~res[3]) | (~res[3] & op_a[3]);
        sreg_d[3] = (op_a[7] & op_b[7] & ~res[7]) | (~op_a[7] & ~op_b[7] & res[7]);
      end
      A_SUB: begin
        res = full[7:0]; sreg_d[0] = full[8];
        sreg_d[5] = (~op_a[3] & op_b[3]) | (op_b[3] & res[3]) | (res[3] & ~op_a[3]);
        sreg_d[3] = (op_a[7] & ~op_b[7] & ~res[7]) | (~op_a[7] & op_b[7] & res[7]);
      end
      A_LOGIC: begin res = lres; sreg_d[3] = 1'b0; end
      A_INC:   begin res = op_a + 8'd1; sreg_d[3] = (res == 8'h80); end
      A_DEC:   begin res = op_a - 8'd1; sreg_d[3] = (res == 8'h7F); end
      default: ;
    endcase
    if (alu != A_NONE) begin
      sreg_d[1] = (res == 8'h00) & (~zkeep | sreg_q[1]);
      sreg_d[2] = res[7];
      sreg_d[4] = res[7] ^ sreg_d[3];
      if (wr) rf_d[dst] = res;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EXEC; pc_q <= '0; addr_q <= '0; wb_q <= '0; w_q <= 1'b0;
      sreg_q <= '0; st_q <= 1'b0; lreg_q <= '0; rf_q <= '0;
    end else if (locked) begin
      state_q <= state_d; pc_q <= pc_d; addr_q <= addr_d; wb_q <= wb_d; w_q <= w_d;
      sreg_q <= sreg_d; st_q <= st_d; lreg_q <= lreg_d; rf_q <= rf_d;
    end else begin
      w_q <= 1'b0;
    end
  end

  assign pc      = pc_q;
  assign address = addr_q;
  assign wb      = wb_q;
  assign w       = w_q;
endmodule

// File: tb/tb_avr_cpu.sv
// Directed program for avr_cpu; stores are logged and compared to hand-computed values.
module tb_avr_cpu;
  logic        clock = 1'b0, reset = 1'b1, locked = 1'b1;
  logic [15:0] pc, ir, address;
  logic [7:0]  data, wb;
  logic        w;
  logic        w_prev = 1'b0;
  int          n_cmp = 0, n_err = 0, act_cyc = 0;

  logic [15:0] prog [0:63];
  logic [7:0]  dmem [0:65535];
  logic [15:0] log_a [$];
  logic [7:0]  log_d [$];
  int          log_t [$];

  logic [15:0] image [47] = '{
    16'h0000, 16'h0000, 16'hE005, 16'hE013, 16'h0F01, 16'h9300, 16'h8000, 16'hE70F,
    16'h9503, 16'hF00B, 16'hE000, 16'h9300, 16'h8001, 16'hE31C, 16'h9310, 16'h0100,
    16'h9140, 16'h0100, 16'h9340, 16'h0101, 16'hE0A0, 16'hE8B1, 16'h915C, 16'h9553,
    16'h935C, 16'hE100, 16'h3100, 16'hF7F9, 16'hEF2F, 16'hE031, 16'h0F23, 16'hF008,
    16'hE727, 16'hF00D, 16'hE626, 16'h9320, 16'h8002, 16'hF409, 16'hE222, 16'h9320,
    16'h8003, 16'hE00F, 16'h2701, 16'h5304, 16'h9300, 16'h8004, 16'hCFFF};
  logic [15:0] exp_a [8] = '{16'h8000, 16'h8001, 16'h0100, 16'h0101,
                             16'h8100, 16'h8002, 16'h8003, 16'h8004};
  logic [7:0]  exp_d [8] = '{8'h08, 8'h80, 8'h3C, 8'h3C, 8'h5B, 8'h00, 8'h22, 8'hFF};

  avr_cpu dut (
    .clock(clock), .reset(reset), .locked(locked), .pc(pc), .ir(ir),
    .address(address), .data(data), .wb(wb), .w(w)
  );

  always #5 clock = ~clock;
  assign ir   = (pc < 16'd64) ? prog[pc[5:0]] : 16'h0000;
  assign data = dmem[address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_pc(input logic [15:0] tgt, input int budget, input string tag);
    for (int i = 0; i < budget && pc !== tgt; i++) @(negedge clock);
    chk(tag, pc, tgt);
  endtask

  always @(posedge clock) begin
    if (w) dmem[address] <= wb;
    if (!reset && locked) act_cyc <= act_cyc + 1;
  end

  always @(negedge clock) begin
    if (w) begin
      chk("w_single_cycle", w_prev, 1'b0);
      log_a.push_back(address);
      log_d.push_back(wb);
      log_t.push_back(act_cyc);
    end
    w_prev = w;
  end

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = (i < 47) ? image[i] : 16'h0000;
    dmem[16'h8100] = 8'h5A;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_w", w, 1'b0);
    chk("rst_wb", wb, 8'h00);
    chk("rst_addr", address, 16'h0000);
    reset = 1'b0;
    @(negedge clock); chk("nop_pc1", pc, 16'd1);
    @(negedge clock); chk("nop_pc2", pc, 16'd2);

    // freeze while LDS sits in its address-word cycle
    wait_pc(16'd17, 50, "reach_lds");
    locked = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("frz_pc", pc, 16'd17);
      chk("frz_addr", address, 16'h0100);
      chk("frz_w", w, 1'b0);
    end
    locked = 1'b1;

    wait_pc(16'd46, 200, "reach_rjmp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rjmp_hold", pc, 16'd46);
    end
    chk("store_count", log_a.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < log_a.size()) begin
        chk($sformatf("st%0d_addr", i), log_a[i], exp_a[i]);
        chk($sformatf("st%0d_data", i), log_d[i], exp_d[i]);
      end
    if (log_t.size() >= 4) chk("lds_sts_gap", log_t[3] - log_t[2], 5);
    chk("mem_0101", dmem[16'h0101], 8'h3C);

    // rerun and reset while LDS is in its load cycle
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_pc(16'd17, 50, "rerun_lds");
    @(negedge clock);
    chk("lds_load_pc", pc, 16'd17);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_w", w, 1'b0);
    chk("midrst_addr", address, 16'h0000);
    log_a.delete(); log_d.delete(); log_t.delete();
    reset = 1'b0;
    wait_pc(16'd7, 30, "post_rst_run");
    @(negedge clock);
    chk("post_rst_count", log_a.size(), 1);
    if (log_a.size() >= 1) begin
      chk("post_rst_addr", log_a[0], 16'h8000);
      chk("post_rst_data", log_d[0], 8'h08);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/avr_cpu.md
Name:
avr_cpu

Overview:
- Compact AVR-subset CPU core with a single-cycle fetch/execute model and a small multi-cycle state machine for data-memory access.
- Fetches 16-bit instruction words from an external program memory indexed by `pc`.
- Reads and writes an external 64 KiB byte-wide data memory through `address`/`data`/`wb`/`w`.
- Holds a 32x8 register file and SREG internally; registers are not memory-mapped.

Parameters:
- None. Widths are fixed: 16-bit pc, 16-bit data address, 8-bit data.

Ports:
- clock    input   1   sole clock; all state updates on its rising edge
- reset    input   1   synchronous, active-high reset
- locked   input   1   run enable (PLL locked); 0 freezes the core
- pc       output  16  word address into program memory (registered)
- ir       input   16  instruction word = progmem[pc]; valid before the next clock edge
- address  output  16  data memory byte address (registered)
- data     input   8   datamem[address]; valid before the next clock edge
- wb       output  8   write data (registered)
- w        output  1   write strobe (registered); memory writes wb at address while high

Behaviour:
- Reset (reset=1 at an edge): pc=0, address=0, wb=0, w=0, SREG=0, all r0..r31=0, state=EXEC. Reset overrides locked.
- locked=0 (no reset): all state is held; w is forced to 0 at that edge.
- Both memories behave as asynchronous-read: ir and data reflect the current pc and address within the same cycle.
- w is high for exactly one cycle per store. Every non-store cycle clears it.

States:
- EXEC:
  - Decode ir and execute.
  - Default next pc = pc+1, state stays EXEC.
- ADDR (second word of LDS/STS): ir holds k.
  - LDS: address<=k, state<=LOAD.
  - STS: address<=k, wb<=Rr, w<=1, pc<=pc+1, state<=EXEC.
- LOAD: Rd<=data, pc<=pc+1, state<=EXEC. The ir fetched in this cycle is not executed.
- LDS/STS in EXEC: pc<=pc+1, latch d/r and the direction, state<=ADDR.
- LD Rd,X (1001000ddddd1100): address<={r27,r26}, state<=LOAD'. LOAD' writes Rd and leaves pc unchanged, because pc already advanced.
- ST X,Rr (1001001rrrrr1100): address<=X, wb<=Rr, w<=1, pc<=pc+1 (single cycle).

Instruction set (d/r are 5 bits; immediate forms use d=16+dddd):
- NOP 0000_0000_0000_0000
- Register-register ALU, opcode in bits 15:10: CPC 000001, SBC 000010, ADD 000011, CP 000101, SUB 000110, ADC 000111, AND 001000, EOR 001001, OR 001010, MOV 001011.
- Immediates: CPI 0011, SBCI 0100, SUBI 0101, ORI 0110, ANDI 0111, LDI 1110.
- LDS 1001000ddddd0000 + k; STS 1001001rrrrr0000 + k.
- INC 1001010ddddd0011; DEC 1001010ddddd1010.
- RJMP 1100 + k12: pc <= pc+1+sext(k12).
- BRBS 111100kkkkkkksss / BRBC 111101kkkkkkksss: if SREG[s] is set (BRBS) or clear (BRBC), pc <= pc+1+sext(k7); else pc <= pc+1.
- All other opcodes execute as NOP.

Flags (SREG bits: C0 Z1 N2 V3 S4 H5):
- Add: C = carry out of bit 7; H = carry out of bit 3; V = signed overflow.
- Sub/compare: C = borrow; H = borrow from bit 3; V = signed overflow.
- All arithmetic: N = R7; S = N^V.
- Z = (R==0), except SBC, CPC and SBCI use Z = Zold & (R==0).
- CP, CPC and CPI update flags only.
- AND, OR, EOR, ANDI, ORI: V=0; N, Z, S updated; C, H unchanged.
- INC: V = (result==0x80). DEC: V = (result==0x7F). Both update N, Z, S; C and H unchanged.
- MOV, LDI, loads, stores and branches leave SREG unchanged.
- Arithmetic wraps modulo 256. Adding 0xFF to 0x01 gives 0x00 with C=1, Z=1, H=1.

Test Plan:
1. Reset high 2 cycles -> pc=0, w=0, wb=0, address=0. Release reset -> pc increments by 1 per cycle on NOPs.
2. LDI r16,0x05; LDI r17,0x03; ADD r16,r17; STS 0x8000,r16 -> exactly one cycle with w=1, address=0x8000, wb=0x08.
3. LDI r16,0x7F; INC r16; BRBS 3,+1 (BRVS) skips one word -> V=1, branch taken. Store r16 -> wb=0x80.
4. STS 0x0100,r17 (0x3C); then LDS r20,0x0100; STS 0x0101,r20 -> the second store has wb=0x3C. LDS takes 3 cycles, STS 2.
5. LDI r16,0x10; CPI r16,0x10; BRBC 1,-1 (BRNE) -> not taken, Z=1. Then RJMP -1 -> pc holds its own address.
6. Drop locked for 5 cycles mid-program -> pc, address and registers are frozen and w=0. Resume -> execution continues identically. Reset asserted mid-LDS -> state=EXEC, pc=0, and no spurious write.
